// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter that shares one external binary_gray
// converter among NREQ requesters. A granted word is registered onto the
// converter input, the Gray result is captured one cycle later, and the
// requester is told with a one-cycle ack/out_valid pulse tagged with its index.
module gray_conv_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] bin_in,
  output logic [WIDTH-1:0]      conv_bin,
  input  logic [WIDTH-1:0]      conv_gray,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      gray_out,
  output logic                  out_valid,
  output logic [IDW-1:0]        out_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q,    state_d;
  logic [IDW-1:0]    rrPtr_q,    rrPtr_d;
  logic [NREQ-1:0]   gnt_q,      gnt_d;
  logic [NREQ-1:0]   ack_q,      ack_d;
  logic [WIDTH-1:0]  convBin_q,  convBin_d;
  logic [WIDTH-1:0]  grayOut_q,  grayOut_d;
  logic [IDW-1:0]    outId_q,    outId_d;
  logic              outValid_q, outValid_d;

  logic              selFound;
  logic [IDW-1:0]    selIdx;
  logic [NREQ-1:0]   selOneHot;
  logic [WIDTH-1:0]  selWord;
  int                candIdx;

  // Round-robin pick: first active request after the last-served index, wrapping.
  always_comb begin
    selFound  = 1'b0;
    selIdx    = '0;
    selOneHot = '0;
    selWord   = '0;
    candIdx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      candIdx = (int'(rrPtr_q) + k) % NREQ;
      if (!selFound && req[candIdx]) begin
        selFound           = 1'b1;
        selIdx             = IDW'(candIdx);
        selOneHot[candIdx] = 1'b1;
        selWord            = bin_in[candIdx*WIDTH +: WIDTH];
      end
    end
  end

  // Sequencer next-state: grant in IDLE, capture the converter in DRIVE, retire in DONE.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    convBin_d  = convBin_q;
    grayOut_d  = grayOut_q;
    outId_d    = outId_q;
    outValid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (selFound) begin
          gnt_d     = selOneHot;
          convBin_d = selWord;
          rrPtr_d   = selIdx;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        grayOut_d  = conv_gray;
        outId_d    = rrPtr_q;
        ack_d      = gnt_q;
        outValid_d = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset makes requester 0 the top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rrPtr_q    <= IDW'(NREQ - 1);
      gnt_q      <= '0;
      ack_q      <= '0;
      convBin_q  <= '0;
      grayOut_q  <= '0;
      outId_q    <= '0;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      convBin_q  <= convBin_d;
      grayOut_q  <= grayOut_d;
      outId_q    <= outId_d;
      outValid_q <= outValid_d;
    end
  end

  assign conv_bin  = convBin_q;
  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign gray_out  = grayOut_q;
  assign out_valid = outValid_q;
  assign out_id    = outId_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: table-driven vectors plus hand-written sequences, with a
// scoreboard of expected {id, gray} results popped whenever out_valid pulses.
module tb_gray_conv_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] bin_in;
  logic [WIDTH-1:0]      conv_bin;
  logic [WIDTH-1:0]      conv_gray;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      gray_out;
  logic                  out_valid;
  logic [IDW-1:0]        out_id;
  logic                  busy;

  typedef struct {
    int         id;
    logic [3:0] gray;
  } sbEntry_t;

  typedef struct {
    int         reqIdx;
    logic [3:0] bin;
    logic [3:0] expGray;
  } vec_t;

  sbEntry_t sbQ[$];
  sbEntry_t expEntry;
  vec_t     vecs[20];
  int       passCount;
  int       checkCount;
  logic [15:0] validTrace;

  gray_conv_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .bin_in    (bin_in),
    .conv_bin  (conv_bin),
    .conv_gray (conv_gray),
    .gnt       (gnt),
    .ack       (ack),
    .gray_out  (gray_out),
    .out_valid (out_valid),
    .out_id    (out_id),
    .busy      (busy)
  );

  // The shared binary_gray converter living beside the arbiter.
  assign conv_gray = conv_bin ^ (conv_bin >> 1);

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a sequence never reaches its end.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Scoreboard monitor: every completion must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("out_valid vs |ack", {31'b0, out_valid}, {31'b0, |ack});
      if (out_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected out_valid", 32'd1, 32'd0);
        end else begin
          expEntry = sbQ.pop_front();
          checkOutput("sb gray_out", {28'b0, gray_out}, {28'b0, expEntry.gray});
          checkOutput("sb out_id", {30'b0, out_id}, expEntry.id);
          checkOutput("sb ack onehot", {28'b0, ack}, 32'd1 << expEntry.id);
        end
      end
    end
  end

  task automatic applyReset();
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One isolated transaction from requester idx, checked cycle by cycle.
  task automatic applyStimulus(input int idx, input logic [3:0] bin, input logic [3:0] expGray);
    sbEntry_t e;
    @(posedge clk);
    #1;
    bin_in[idx*WIDTH +: WIDTH] = bin;
    req = 4'b0001 << idx;
    e.id = idx;
    e.gray = expGray;
    sbQ.push_back(e);
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    checkOutput("drive gnt", {28'b0, gnt}, 32'd1 << idx);
    checkOutput("drive conv_bin", {28'b0, conv_bin}, {28'b0, bin});
    checkOutput("drive busy", {31'b0, busy}, 32'd1);
    checkOutput("drive out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("done out_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("idle busy", {31'b0, busy}, 32'd0);
    checkOutput("idle gnt", {28'b0, gnt}, 32'd0);
    checkOutput("hold gray_out", {28'b0, gray_out}, {28'b0, expGray});
  endtask

  task automatic pushExp(input int id, input logic [3:0] gray);
    sbEntry_t e;
    e.id = id;
    e.gray = gray;
    sbQ.push_back(e);
  endtask

  // Main sequence.
  initial begin
    passCount  = 0;
    checkCount = 0;
    rst_n  = 1'b0;
    req    = '0;
    bin_in = '0;

    vecs[0]  = '{0, 4'd0,  4'h0};
    vecs[1]  = '{0, 4'd1,  4'h1};
    vecs[2]  = '{0, 4'd2,  4'h3};
    vecs[3]  = '{0, 4'd3,  4'h2};
    vecs[4]  = '{0, 4'd4,  4'h6};
    vecs[5]  = '{0, 4'd5,  4'h7};
    vecs[6]  = '{0, 4'd6,  4'h5};
    vecs[7]  = '{0, 4'd7,  4'h4};
    vecs[8]  = '{0, 4'd8,  4'hC};
    vecs[9]  = '{0, 4'd9,  4'hD};
    vecs[10] = '{0, 4'd10, 4'hF};
    vecs[11] = '{0, 4'd11, 4'hE};
    vecs[12] = '{0, 4'd12, 4'hA};
    vecs[13] = '{0, 4'd13, 4'hB};
    vecs[14] = '{0, 4'd14, 4'h9};
    vecs[15] = '{0, 4'd15, 4'h8};
    vecs[16] = '{1, 4'd11, 4'hE};
    vecs[17] = '{2, 4'd13, 4'hB};
    vecs[18] = '{3, 4'd6,  4'h5};
    vecs[19] = '{3, 4'd14, 4'h9};

    // Reset state.
    applyReset();
    @(negedge clk);
    checkOutput("reset gnt", {28'b0, gnt}, 32'd0);
    checkOutput("reset ack", {28'b0, ack}, 32'd0);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset conv_bin", {28'b0, conv_bin}, 32'd0);
    checkOutput("reset gray_out", {28'b0, gray_out}, 32'd0);
    checkOutput("reset out_id", {30'b0, out_id}, 32'd0);

    // Single transaction: bin0=5 -> gray 0111.
    applyStimulus(0, 4'd5, 4'h7);

    // Table sweep.
    for (int i = 0; i < 20; i++) applyStimulus(vecs[i].reqIdx, vecs[i].bin, vecs[i].expGray);

    // All requesters continuously active: order 0,1,2,3,0, one ack every 3 cycles.
    applyReset();
    bin_in = {4'd12, 4'd9, 4'd6, 4'd3};
    pushExp(0, 4'h2);
    pushExp(1, 4'h5);
    pushExp(2, 4'hD);
    pushExp(3, 4'hA);
    pushExp(0, 4'h2);
    @(posedge clk);
    #1 req = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      validTrace[k] = out_valid;
      if (k == 13) req = '0;
    end
    checkOutput("rr ack spacing", {16'b0, validTrace}, 32'h4924);
    checkOutput("rr drained", sbQ.size(), 32'd0);

    // After serving 2, requester 3 beats 2.
    applyReset();
    bin_in = {4'd3, 4'd2, 4'd0, 4'd0};
    applyStimulus(2, 4'd2, 4'h3);
    @(posedge clk);
    #1 req = 4'b1100;
    pushExp(3, 4'h2);
    pushExp(2, 4'h3);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rr grant 3 first", {28'b0, gnt}, 32'h8);
    @(posedge clk);
    #1 req = 4'b0100;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rr grant 2 next", {28'b0, gnt}, 32'h4);
    @(posedge clk);
    #1 req = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rr idle busy", {31'b0, busy}, 32'd0);

    // bin_in and req changes during DRIVE do not disturb the transaction.
    applyReset();
    @(posedge clk);
    #1;
    bin_in[3:0] = 4'd4;
    req = 4'b0001;
    pushExp(0, 4'h6);
    @(posedge clk);
    #1;
    bin_in[3:0] = 4'd9;
    req = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("late change valid", {31'b0, out_valid}, 32'd1);
    checkOutput("late change ack", {28'b0, ack}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("late change gray held", {28'b0, gray_out}, 32'h6);

    // Asynchronous reset during DRIVE drops the transaction.
    @(posedge clk);
    #1;
    bin_in[3:0] = 4'd7;
    req = 4'b0001;
    @(posedge clk);
    #2;
    checkOutput("pre-reset busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    req = '0;
    #1;
    checkOutput("async rst gnt", {28'b0, gnt}, 32'd0);
    checkOutput("async rst ack", {28'b0, ack}, 32'd0);
    checkOutput("async rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("async rst busy", {31'b0, busy}, 32'd0);
    checkOutput("async rst conv_bin", {28'b0, conv_bin}, 32'd0);
    checkOutput("async rst gray_out", {28'b0, gray_out}, 32'd0);
    checkOutput("async rst out_id", {30'b0, out_id}, 32'd0);
    #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    applyStimulus(1, 4'd10, 4'hF);

    checkOutput("scoreboard drained", sbQ.size(), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
